ysyx_22050710_dmem_bridge: RTL and testbench

Multi-cycle data-memory bridge between the execute stage and the data memory bus. It accepts one load/store request per transaction and computes the 8-byte-aligned bus address, the byte write mask and the shifted write data. It then drives a valid/ready request to memory and returns the load data right-aligned and zero-filled. The execute stage consumes `o_rdata` and performs sign/zero extension using the same MemOP encoding.

---
 rtl/ysyx_22050710_pkg.sv | 38 +++
 rtl/ysyx_22050710_dmem_align.sv | 33 +++
 rtl/ysyx_22050710_dmem_bridge.sv | 136 +++++++++++++
 tb/tb_ysyx_22050710_dmem_bridge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_pkg.sv
// rtl/ysyx_22050710_pkg.sv - shared MemOP, size-mask and FSM definitions for the dmem bridge
package ysyx_22050710_pkg;

    localparam logic [2:0] MEMOP_DWORD   = 3'b110;
    localparam logic [2:0] MEMOP_ILLEGAL = 3'b111;

    localparam logic [7:0] SIZE_MASK_B = 8'h01;
    localparam logic [7:0] SIZE_MASK_H = 8'h03;
    localparam logic [7:0] SIZE_MASK_W = 8'h0F;
    localparam logic [7:0] SIZE_MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_RESP
    } state_e;

    // Byte-lane mask for an access size; the illegal encoding enables no lanes.
    function automatic logic [7:0] size_mask(input logic [2:0] memop);
        case (memop[2:1])
            2'b00:   size_mask = SIZE_MASK_B;
            2'b01:   size_mask = SIZE_MASK_H;
            2'b10:   size_mask = SIZE_MASK_W;
            default: size_mask = (memop == MEMOP_ILLEGAL) ? 8'h00 : SIZE_MASK_D;
        endcase
    endfunction

    function automatic logic access_error(input logic [2:0] memop, input logic [2:0] off);
        case (memop[2:1])
            2'b00:   access_error = 1'b0;
            2'b01:   access_error = off[0];
            2'b10:   access_error = (off[1:0] != 2'b00);
            default: access_error = (memop == MEMOP_ILLEGAL) || (off != 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050710_dmem_align.sv
// rtl/ysyx_22050710_dmem_align.sv - byte-lane shift for store data/mask and load extraction
module ysyx_22050710_dmem_align
    import ysyx_22050710_pkg::*;
(
    input  logic [2:0]  i_off,
    input  logic [2:0]  i_memop,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_wmask,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata
);

    logic [7:0]  size;
    logic [5:0]  bit_sh;
    logic [63:0] size_bits;
    logic [63:0] lane_bits;

    always_comb begin
        size      = size_mask(i_memop);
        bit_sh    = {i_off, 3'b000};
        o_wmask   = size << i_off;
        size_bits = '0;
        lane_bits = '0;
        for (int i = 0; i < 8; i++) begin
            size_bits[i*8 +: 8] = {8{size[i]}};
            lane_bits[i*8 +: 8] = {8{o_wmask[i]}};
        end
        o_wdata = (i_wdata << bit_sh) & lane_bits;
        o_rdata = (i_rdata >> bit_sh) & size_bits;
    end

endmodule

// File: rtl/ysyx_22050710_dmem_bridge.sv
// rtl/ysyx_22050710_dmem_bridge.sv - multi-cycle load/store bridge from execute stage to data memory
module ysyx_22050710_dmem_bridge
    import ysyx_22050710_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_MemOP,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_resp_err,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [7:0]        o_mem_wmask,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        memop_q, memop_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [7:0]        al_wmask;
    logic [63:0]       al_wdata;
    logic [63:0]       al_rdata;
    logic              in_req;
    logic              drive_store;

    // Everything is derived from the latched request, so memory outputs never
    // depend combinationally on i_mem_ready / i_mem_rvalid.
    ysyx_22050710_dmem_align u_align (
        .i_off   (addr_q[2:0]),
        .i_memop (memop_q),
        .i_wdata (wdata_q),
        .i_rdata (i_mem_rdata),
        .o_wmask (al_wmask),
        .o_wdata (al_wdata),
        .o_rdata (al_rdata)
    );

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        memop_d = memop_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    wen_d   = i_wen;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    memop_d = i_MemOP;
                    err_d   = access_error(i_MemOP, i_addr[2:0]);
                    if (access_error(i_MemOP, i_addr[2:0])) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (i_mem_ready) begin
                    if (wen_q) begin
                        state_d = ST_RESP;
                    end else if (i_mem_rvalid) begin
                        rdata_d = al_rdata;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end
            end
            ST_WAIT_R: begin
                if (i_mem_rvalid) begin
                    rdata_d = al_rdata;
                    state_d = ST_RESP;
                end
            end
            default: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            memop_q <= 3'b000;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            memop_q <= memop_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_req       = (state_q == ST_REQ);
    assign drive_store  = in_req && wen_q;
    assign o_req_ready  = (state_q == ST_IDLE);
    assign o_resp_valid = (state_q == ST_RESP);
    assign o_resp_err   = err_q;
    assign o_rdata      = rdata_q;
    assign o_mem_valid  = in_req;
    assign o_mem_wen    = drive_store;
    assign o_mem_addr   = {addr_q[ADDR_W-1:3], 3'b000};
    assign o_mem_wmask  = drive_store ? al_wmask : 8'h00;
    assign o_mem_wdata  = drive_store ? al_wdata : '0;

endmodule

// File: tb/tb_ysyx_22050710_dmem_bridge.sv
// tb/tb_ysyx_22050710_dmem_bridge.sv - scoreboard bench for the dmem bridge
module tb_ysyx_22050710_dmem_bridge;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_wen = 1'b0;
    logic [63:0] i_addr = '0;
    logic [63:0] i_wdata = '0;
    logic [2:0]  i_MemOP = 3'b000;
    logic        o_resp_valid;
    logic [63:0] o_rdata;
    logic        o_resp_err;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b0;
    logic        o_mem_wen;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_rvalid = 1'b0;
    logic [63:0] i_mem_rdata = '0;

    ysyx_22050710_dmem_bridge dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_wen        (i_wen),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_MemOP      (i_MemOP),
        .o_resp_valid (o_resp_valid),
        .o_rdata      (o_rdata),
        .o_resp_err   (o_resp_err),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .o_mem_wen    (o_mem_wen),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wmask  (o_mem_wmask),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [7:0]  wmask;
        logic [63:0] wdata;
    } memreq_t;

    resp_t       resp_q[$];
    memreq_t     mem_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [63:0] model_rdata = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge i_clk) begin
        if (o_resp_valid) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("resp_err", {63'd0, o_resp_err}, {63'd0, e.err});
                chk("resp_rdata", o_rdata, e.rdata);
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Memory-request monitor: checked every cycle the request is presented
    always @(negedge i_clk) begin
        if (o_mem_valid) begin
            if (mem_q.size() == 0) begin
                chk("unexpected_mem_valid", 64'd1, 64'd0);
            end else begin
                chk("mem_addr", o_mem_addr, mem_q[0].addr);
                chk("mem_wen", {63'd0, o_mem_wen}, {63'd0, mem_q[0].wen});
                if (mem_q[0].wen) begin
                    chk("mem_wmask", {56'd0, o_mem_wmask}, {56'd0, mem_q[0].wmask});
                    chk("mem_wdata", o_mem_wdata, mem_q[0].wdata);
                end
                if (i_mem_ready) void'(mem_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One transaction: ready after rdy_dly cycles in REQ, rvalid rv_k cycles after ready.
    task automatic run(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [2:0] memop, input int rdy_dly, input int rv_k,
                       input logic [63:0] mdata, input logic exp_err,
                       input logic [63:0] exp_maddr, input logic [7:0] exp_wmask,
                       input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                       input int lat, input logic bogus);
        resp_t   r;
        memreq_t m;
        int      acc;
        if (!exp_err) begin
            m.wen = wen; m.addr = exp_maddr; m.wmask = exp_wmask; m.wdata = exp_wdata;
            mem_q.push_back(m);
        end
        i_wen = wen; i_addr = addr; i_wdata = wdata; i_MemOP = memop;
        i_req_valid = 1'b1;
        step();
        i_req_valid = 1'b0;
        acc = cyc;
        if (exp_err) model_rdata = 64'd0;
        else if (!wen) model_rdata = exp_rdata;
        r.err = exp_err; r.rdata = model_rdata; r.cyc = acc + lat - 1;
        resp_q.push_back(r);
        if (!exp_err) begin
            for (int i = 0; i < rdy_dly; i++) begin
                if (bogus) begin
                    i_req_valid = 1'b1; i_addr = 64'h0000_0000_9000_0100; i_wen = 1'b0;
                end
                step();
                chk("req_ready_busy", {63'd0, o_req_ready}, 64'd0);
            end
            i_req_valid = 1'b0;
            i_mem_ready = 1'b1;
            if (!wen && rv_k == 0) begin
                i_mem_rvalid = 1'b1; i_mem_rdata = mdata;
            end
            step();
            i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
            if (!wen && rv_k > 0) begin
                for (int i = 1; i < rv_k; i++) step();
                i_mem_rvalid = 1'b1; i_mem_rdata = mdata;
                step();
                i_mem_rvalid = 1'b0;
            end
        end
        repeat (3) step();
    endtask

    initial begin
        repeat (2) step();
        i_rst_n = 1'b1;
        step();
        chk("rst_req_ready", {63'd0, o_req_ready}, 64'd1);
        chk("rst_outputs", {o_resp_valid, o_resp_err, o_mem_valid, o_mem_wen, 60'd0}, 64'd0);
        chk("rst_rdata", o_rdata, 64'd0);
        chk("rst_mem_bus", o_mem_addr | o_mem_wdata | {56'd0, o_mem_wmask}, 64'd0);

        // wen addr wdata memop rdy rvk mdata err maddr wmask wdata rdata lat bogus
        run(1, 64'h8000_0013, 64'hAB, 3'b000, 0, 0, 0, 0,
            64'h8000_0010, 8'h08, 64'h0000_0000_AB00_0000, 0, 2, 0);
        run(0, 64'h8000_0006, 0, 3'b010, 0, 2, 64'h1234_5678_9ABC_DEF0, 0,
            64'h8000_0000, 0, 0, 64'h0000_0000_0000_1234, 4, 0);
        run(0, 64'h8000_0002, 0, 3'b100, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        run(0, 64'h8000_0000, 0, 3'b111, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        run(1, 64'h8000_0008, 64'h1122_3344_5566_7788, 3'b110, 5, 0, 0, 0,
            64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 0, 7, 1);
        run(0, 64'h8000_0004, 0, 3'b101, 0, 0, 64'hCAFE_BABE_DEAD_BEEF, 0,
            64'h8000_0000, 0, 0, 64'h0000_0000_CAFE_BABE, 2, 0);
        run(0, 64'h8000_0001, 0, 3'b001, 0, 1, 64'hCAFE_BABE_DEAD_BEEF, 0,
            64'h8000_0000, 0, 0, 64'h0000_0000_0000_00BE, 3, 0);
        run(1, 64'h8000_000A, 64'hFFFF_FFFF_FFFF_BEEF, 3'b011, 0, 0, 0, 0,
            64'h8000_0008, 8'h0C, 64'h0000_0000_BEEF_0000, 0, 2, 0);
        run(1, 64'h8000_0004, 64'h1234_5678, 3'b100, 1, 0, 0, 0,
            64'h8000_0000, 8'hF0, 64'h1234_5678_0000_0000, 0, 3, 0);

        // Reset while waiting for read data: no response, outputs cleared.
        begin
            memreq_t m;
            m.wen = 0; m.addr = 64'h8000_0010; m.wmask = 0; m.wdata = 0;
            mem_q.push_back(m);
            i_wen = 0; i_addr = 64'h8000_0010; i_MemOP = 3'b110; i_req_valid = 1'b1;
            step();
            i_req_valid = 1'b0;
            i_mem_ready = 1'b1;
            step();
            i_mem_ready = 1'b0;
            chk("wait_r_busy", {62'd0, o_req_ready, o_mem_valid}, 64'd0);
            i_rst_n = 1'b0;
            step();
            i_rst_n = 1'b1;
            model_rdata = 64'd0;
            chk("abort_outputs", {o_resp_valid, o_resp_err, o_mem_valid, o_mem_wen, 60'd0}, 64'd0);
            chk("abort_rdata", o_rdata, 64'd0);
            chk("abort_mem_bus", o_mem_addr | o_mem_wdata | {56'd0, o_mem_wmask}, 64'd0);
            chk("abort_req_ready", {63'd0, o_req_ready}, 64'd1);
            i_mem_rvalid = 1'b1; i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            step();
            i_mem_rvalid = 1'b0;
            repeat (3) step();
        end

        run(0, 64'h8000_0003, 0, 3'b010, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        run(0, 64'h8000_0018, 0, 3'b110, 0, 3, 64'h0102_0304_0506_0708, 0,
            64'h8000_0018, 0, 0, 64'h0102_0304_0506_0708, 5, 0);
        run(0, 64'h8000_0004, 0, 3'b110, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

        chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
